// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_if
// Description : Field-beat input, memory-write output and status bundle
//               for the instruction encoder.
// Revision    : 1.0
// ============================================================================
interface instr_encoder_if #(
    parameter int ADDR_W = 15
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [5:0]        rs1;
    logic [5:0]        rs2;
    logic [5:0]        rd;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [7:0]        err_cnt;
    logic [15:0]       err_idx;

    modport slave (
        input  start, base_addr, in_valid, opcode, funct3, funct7,
               rs1, rs2, rd, imm, out_ready,
        output in_ready, out_valid, out_addr, out_data,
               busy, done, err, err_cnt, err_idx
    );

    modport master (
        output start, base_addr, in_valid, opcode, funct3, funct7,
               rs1, rs2, rd, imm, out_ready,
        input  in_ready, out_valid, out_addr, out_data,
               busy, done, err, err_cnt, err_idx
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Packs instruction field beats into 32-bit words and streams
//               them to instruction memory through an output FIFO.
// Revision    : 1.0
// ============================================================================
module instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 15
) (
    input  wire logic     clk,
    input  wire logic     rst,
    instr_encoder_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       beat_q, beat_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [15:0]       err_idx_q, err_idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0]       fifo_mem_q [FIFO_DEPTH];

    logic [31:0] w_word;
    logic        w_enc_err;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    // Field packer plus range checks; immediate bits override rs2/funct7/rd
    // slots depending on the instruction form.
    always_comb begin
        w_word    = 32'h0;
        w_enc_err = 1'b0;
        case (bus.opcode)
            4'h0, 4'hD: begin
                w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            end
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hB: begin
                w_word    = {bus.imm[11], bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                w_enc_err = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
            end
            4'h6, 4'hC: begin
                w_word    = {bus.imm[11], bus.imm[11:6], bus.rs2, bus.rs1, bus.funct3,
                             bus.imm[5:0], bus.opcode};
                w_enc_err = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
            end
            4'h7: begin
                w_word    = {bus.imm[13], bus.imm[13:8], bus.rs2, bus.rs1, bus.funct3,
                             bus.imm[7:2], bus.opcode};
                w_enc_err = !((&bus.imm[31:13]) || !(|bus.imm[31:13])) || (|bus.imm[1:0]);
            end
            4'h8, 4'h9: begin
                w_word    = {{2{bus.imm[31]}}, bus.imm[31:12], bus.rd, bus.opcode};
                w_enc_err = |bus.imm[11:0];
            end
            4'hA: begin
                w_word    = {{2{bus.imm[21]}}, bus.imm[21:2], bus.rd, bus.opcode};
                w_enc_err = !((&bus.imm[31:21]) || !(|bus.imm[31:21])) || (|bus.imm[1:0]);
            end
            default: begin
                w_enc_err = 1'b1;
            end
        endcase
    end

    // in_ready looks only at registered occupancy, so a same-cycle pop
    // cannot open the input.
    assign w_in_ready = (state_q == S_LOAD) && (count_q < C_DEPTH);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_push     = w_accept && !w_enc_err;
    assign w_pop      = (count_q != '0) && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        err_idx_d = err_idx_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + CNT_W'(w_push) - CNT_W'(w_pop);

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            addr_d   = addr_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d   = S_LOAD;
                    addr_d    = bus.base_addr;
                    beat_d    = 16'h0;
                    err_d     = 1'b0;
                    err_cnt_d = 8'h0;
                    err_idx_d = 16'h0;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    beat_d = beat_q + 16'h1;
                    if (w_enc_err) begin
                        err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'h1;
                        end
                        if (!err_q) begin
                            err_idx_d = beat_q;
                        end
                    end else if (w_word == 32'h0) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && (count_q == C_ONE)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            beat_q    <= 16'h0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h0;
            err_idx_q <= 16'h0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            err_idx_q <= err_idx_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            fifo_mem_q[wr_ptr_q] <= w_word;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = fifo_mem_q[rd_ptr_q];
    assign bus.out_addr  = addr_q;
    assign bus.busy      = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.err_idx   = err_idx_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Scoreboard bench for instr_encoder with directed beats.
// Revision    : 1.0
// ============================================================================
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst;

    instr_encoder_if #(.ADDR_W(15)) bus ();

    instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [46:0] exp_q [$];
    logic [14:0] exp_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                         bus.out_addr, bus.out_data);
            end else begin
                logic [46:0] e;
                e = exp_q.pop_front();
                check("wr_addr", {17'h0, bus.out_addr}, {17'h0, e[46:32]});
                check("wr_data", bus.out_data, e[31:0]);
            end
        end
    end

    task automatic do_start(input logic [14:0] b);
        bus.base_addr = b;
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start  = 1'b0;
        exp_addr      = b;
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [5:0] r1, input logic [5:0] r2, input logic [5:0] rdv,
                        input logic [31:0] immv, input logic [31:0] exp_word,
                        input logic exp_err);
        bit ok;
        ok = 1'b0;
        if (!exp_err) begin
            exp_q.push_back({exp_addr, exp_word});
            exp_addr = exp_addr + 15'h1;
        end
        bus.opcode = op;  bus.funct3 = f3; bus.funct7 = f7;
        bus.rs1 = r1;     bus.rs2 = r2;    bus.rd = rdv;  bus.imm = immv;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: got no in_ready expected accept of opcode 0x%0h", op);
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) $display("FAIL drain_timeout: got out_valid 1 expected FIFO to empty");
        check("done_after_drain", {31'h0, bus.done}, 32'h1);
        check("busy_after_drain", {31'h0, bus.busy}, 32'h0);
        check("scoreboard_empty", exp_q.size(), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
        bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.imm = '0;
        exp_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'h0, bus.in_ready},  32'h0);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_busy",      {31'h0, bus.busy},      32'h0);
        check("rst_done",      {31'h0, bus.done},      32'h0);
        check("rst_err",       {31'h0, bus.err},       32'h0);
        check("rst_err_cnt",   {24'h0, bus.err_cnt},   32'h0);
        check("rst_err_idx",   {16'h0, bus.err_idx},   32'h0);
        rst = 1'b0;

        // Encoding of every form, error cases, end marker.
        do_start(15'h0100);
        bus.out_ready = 1'b1;
        send(4'h1, 3'd0, 7'd0, 6'd0, 6'd0, 6'd5, 32'hFFFFFFFF, 32'hFFF80051, 1'b0);
        check("latency_valid", {31'h0, bus.out_valid}, 32'h1);
        send(4'h6, 3'd2, 7'd0, 6'd2, 6'd3, 6'd0, 32'h00000008, 32'h00184886, 1'b0);
        send(4'h7, 3'd0, 7'd0, 6'd0, 6'd0, 6'd0, 32'h00000006, 32'h0, 1'b1);
        check("beq_err",     {31'h0, bus.err},     32'h1);
        check("beq_err_cnt", {24'h0, bus.err_cnt}, 32'h1);
        check("beq_err_idx", {16'h0, bus.err_idx}, 32'h2);
        send(4'h7, 3'd1, 7'd0, 6'd1, 6'd2, 6'd0, 32'h00000008, 32'h00102427, 1'b0);
        send(4'hE, 3'd0, 7'd0, 6'd0, 6'd0, 6'd0, 32'h00000000, 32'h0, 1'b1);
        send(4'h2, 3'd0, 7'd0, 6'd0, 6'd0, 6'd0, 32'h00000800, 32'h0, 1'b1);
        send(4'h9, 3'd0, 7'd0, 6'd0, 6'd0, 6'd0, 32'h00000001, 32'h0, 1'b1);
        send(4'h8, 3'd0, 7'd0, 6'd0, 6'd0, 6'd3, 32'h12345000, 32'h048D1438, 1'b0);
        send(4'hA, 3'd0, 7'd0, 6'd0, 6'd0, 6'd1, 32'hFFFFFFFC, 32'hFFFFFC1A, 1'b0);
        send(4'hC, 3'd0, 7'd0, 6'd0, 6'd0, 6'd0, 32'hFFFFFFFF, 32'hFE0003FC, 1'b0);
        send(4'hD, 3'd7, 7'h7F, 6'd63, 6'd63, 6'd1, 32'hDEADBEEF, 32'hFFFFFC1D, 1'b0);
        send(4'h7, 3'd0, 7'd0, 6'd0, 6'd0, 6'd0, 32'h00002000, 32'h0, 1'b1);
        send(4'h7, 3'd0, 7'd0, 6'd0, 6'd0, 6'd0, 32'hFFFFE000, 32'hC0000007, 1'b0);
        send(4'h3, 3'd0, 7'd0, 6'd0, 6'd0, 6'd0, 32'hFFFFF800, 32'hC0000003, 1'b0);
        send(4'h0, 3'd0, 7'd0, 6'd0, 6'd0, 6'd0, 32'h00000000, 32'h00000000, 1'b0);
        check("marker_in_ready", {31'h0, bus.in_ready}, 32'h0);
        check("marker_busy",     {31'h0, bus.busy},     32'h1);
        check("total_err_cnt",   {24'h0, bus.err_cnt},  32'h5);
        check("first_err_idx",   {16'h0, bus.err_idx},  32'h2);
        wait_done();

        // Backpressure: FIFO fills, in_ready drops, start is ignored mid-load.
        do_start(15'h0200);
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            logic [31:0] w;
            w = (32'(k) << 19) | (32'(k) << 4) | 32'h1;
            send(4'h1, 3'd0, 7'd0, 6'd0, 6'd0, 6'(k), 32'(k), w, 1'b0);
        end
        check("full_in_ready",  {31'h0, bus.in_ready},  32'h0);
        check("full_out_valid", {31'h0, bus.out_valid}, 32'h1);
        bus.base_addr = 15'h0555;
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("full_hold_in_ready", {31'h0, bus.in_ready}, 32'h0);
        check("start_ignored_busy", {31'h0, bus.busy},     32'h1);
        bus.out_ready = 1'b1;
        send(4'h0, 3'd0, 7'd0, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0);
        wait_done();

        // Address counter wraps at 2^ADDR_W.
        do_start(15'h7FFE);
        bus.out_ready = 1'b1;
        send(4'h1, 3'd0, 7'd0, 6'd0, 6'd0, 6'd5, 32'd5, 32'h00280051, 1'b0);
        send(4'h1, 3'd0, 7'd0, 6'd0, 6'd0, 6'd6, 32'd6, 32'h00300061, 1'b0);
        send(4'h1, 3'd0, 7'd0, 6'd0, 6'd0, 6'd7, 32'd7, 32'h00380071, 1'b0);
        send(4'h0, 3'd0, 7'd0, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0);
        check("wrap_marker_in_ready", {31'h0, bus.in_ready}, 32'h0);
        wait_done();

        // Reset mid-load discards buffered words.
        do_start(15'h0300);
        bus.out_ready = 1'b0;
        send(4'h1, 3'd0, 7'd0, 6'd0, 6'd0, 6'd1, 32'd1, 32'h00080011, 1'b0);
        send(4'h1, 3'd0, 7'd0, 6'd0, 6'd0, 6'd2, 32'd2, 32'h00100021, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("midrst_busy",      {31'h0, bus.busy},      32'h0);
        check("midrst_in_ready",  {31'h0, bus.in_ready},  32'h0);
        check("midrst_done",      {31'h0, bus.done},      32'h0);
        rst = 1'b0;
        do_start(15'h0400);
        bus.out_ready = 1'b1;
        send(4'h1, 3'd0, 7'd0, 6'd0, 6'd0, 6'd9, 32'd9, 32'h00480091, 1'b0);
        send(4'h0, 3'd0, 7'd0, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0);
        wait_done();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 15, instruction-memory word-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse beginning a program load.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address, sampled on accepted start.
REQ-007 SHALL have port in_valid / in_ready  input / output  1 / 1  field-beat handshake.
REQ-008 SHALL have ports opcode 4, funct3 3, funct7 7, rs1 6, rs2 6, rd 6, imm 32, all inputs, holding the fields of one instruction.
REQ-009 SHALL have port out_valid / out_ready  output / input  1 / 1  memory-write handshake.
REQ-010 SHALL have ports out_addr  output  ADDR_W  and out_data  output  32  write address and encoded word.
REQ-011 SHALL have ports busy 1, done 1, err 1, err_cnt 8, err_idx 16, all outputs, giving status.

Function
REQ-012 Field placement SHALL be: opcode[3:0], rd[9:4], funct3[12:10], rs1[18:13], rs2[24:19], funct7[31:25].
REQ-013 R-form (opcode 0000, 1101) SHALL place all six fields; imm ignored.
REQ-014 I-form (0001, 0010, 0011, 0100, 0101, 1011) SHALL place imm[11:0] at [30:19] and imm[11] at [31], overriding rs2/funct7; rd, rs1, funct3 placed.
REQ-015 S-form (0110, 1100) SHALL place imm[11:6] at [30:25], imm[5:0] at [9:4], imm[11] at [31]; rs1, rs2, funct3 placed.
REQ-016 B-form (0111) SHALL place imm[13:8] at [30:25], imm[7:2] at [9:4], imm[13] at [31]; rs1, rs2, funct3 placed.
REQ-017 L-form (1000, 1001) SHALL place imm[31:12] at [29:10], imm[31] at [31:30], rd at [9:4].
REQ-018 J-form (1010) SHALL place imm[21:2] at [29:10], imm[21] at [31:30], rd at [9:4].
REQ-019 Encode error SHALL be: opcode 1110/1111; I/S imm not sign-representable in 12 bits; B imm not in 14 signed bits or imm[1:0]!=0; J imm not in 22 signed bits or imm[1:0]!=0; L imm[11:0]!=0.
REQ-020 FSM states SHALL be IDLE, LOAD, DRAIN, DONE.
REQ-021 start in IDLE or DONE SHALL go to LOAD, load address counter from base_addr, clear done, err, err_cnt, err_idx, beat index; start in LOAD/DRAIN SHALL be ignored.
REQ-022 in_ready SHALL be 1 only in LOAD with FIFO occupancy < FIFO_DEPTH; a simultaneous pop SHALL NOT raise in_ready that cycle.
REQ-023 A beat accepted without error SHALL be pushed into FIFO and appear at out_valid/out_data the next cycle if FIFO was empty (latency 1).
REQ-024 A beat with encode error SHALL NOT be pushed; err set sticky; err_cnt incremented, saturating at 255; err_idx captures beat index of first error only.
REQ-025 Beat index SHALL increment per accepted beat (error or not), 16-bit, wrapping.
REQ-026 An accepted error-free beat encoding to 32'h00000000 (end marker) SHALL be pushed and SHALL move FSM to DRAIN; no further beats accepted.
REQ-027 out_valid SHALL equal FIFO non-empty; out_data SHALL be FIFO head and stable while out_valid && !out_ready.
REQ-028 out_addr SHALL be the address counter; counter increments on each out handshake, modulo 2^ADDR_W.
REQ-029 DRAIN SHALL go to DONE the cycle after the handshake that empties the FIFO; done SHALL be 1 in DONE, held until next start.
REQ-030 busy SHALL be 1 in LOAD and DRAIN, else 0.

Reset
REQ-031 rst SHALL force IDLE, empty FIFO, address counter 0, beat index 0, in_ready 0, out_valid 0, busy 0, done 0, err 0, err_cnt 0, err_idx 0, regardless of state, including mid-LOAD or DRAIN; FIFO contents discarded.
REQ-032 out_data and out_addr SHALL be don't-care while out_valid is 0.

Verification
REQ-033 base_addr 0x0100, start; addi opcode 0001 rd 5 rs1 0 funct3 000 imm 0xFFFFFFFF, out_ready 1 -> next cycle out_valid 1, out_addr 0x0100, out_data 0xFFF80051.
REQ-034 sw opcode 0110 rs1 2 rs2 3 funct3 010 imm 8 -> out_data 0x00184886.
REQ-035 beq opcode 0111 imm 6 -> no write, err 1, err_cnt 1, err_idx = that beat's index; next valid beat written at unchanged address.
REQ-036 out_ready 0, push FIFO_DEPTH=4 beats -> in_ready 0 after 4th accept; release out_ready -> 4 writes, consecutive addresses, data in order.
REQ-037 three valid beats then all-zero R-form beat, base 0x7FFE -> writes at 0x7FFE, 0x7FFF, 0x0000, 0x0001 (last data 0); in_ready 0 after marker; done 1 cycle after 4th handshake.
REQ-038 rst asserted mid-LOAD with 2 words buffered -> next cycle out_valid 0, busy 0, state IDLE; new start loads fresh with no stale writes.
